// File: rtl/lm80c_ps2_keyboard.sv
// PS/2 set-2 keyboard receiver and decoder that maintains the LM80C 8x8 active-low key matrix.
// Define LM80C_KBD_HOTKEY_EN to make F12 (code 07) drive reset_req while it is held.
module lm80c_ps2_keyboard #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 50000
) (
    input  logic            sys_clock,
    input  logic            RESET,
    input  logic            ps2_clk,
    input  logic            ps2_data,
    output logic [7:0][7:0] KM,
    output logic            rx_err,
    output logic            reset_req
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        PARITY,
        STOP
    } rx_state_t;

    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          filt_clk;
    logic          filt_clk_d;
    logic [FW-1:0] filt_cnt;
    logic          strobe;
    logic          data_s;

    rx_state_t     rx_state;
    logic [7:0]    shift_reg;
    logic [2:0]    bit_cnt;
    logic          parity_ok;
    logic [TW-1:0] tmo_cnt;
    logic          byte_valid;
    logic [7:0]    rx_byte;

    logic          ext;
    logic          rel;
    logic [2:0]    skip;
    logic [6:0]    key_map;

    assign data_s = data_sync[1];
    assign strobe = filt_clk_d & ~filt_clk;

    // {hit, row, col} for a scancode; bit 8 of the key is the E0 extension flag
    function automatic logic [6:0] map_key(input logic [8:0] key);
        logic [6:0] m;
        m = 7'd0;
        case (key)
            9'h016: m = {1'b1, 3'd0, 3'd0};
            9'h01E: m = {1'b1, 3'd0, 3'd1};
            9'h026: m = {1'b1, 3'd0, 3'd2};
            9'h025: m = {1'b1, 3'd0, 3'd3};
            9'h02E: m = {1'b1, 3'd0, 3'd4};
            9'h036: m = {1'b1, 3'd0, 3'd5};
            9'h03D: m = {1'b1, 3'd0, 3'd6};
            9'h05A: m = {1'b1, 3'd0, 3'd7};
            9'h01C: m = {1'b1, 3'd1, 3'd0};
            9'h032: m = {1'b1, 3'd1, 3'd1};
            9'h021: m = {1'b1, 3'd1, 3'd2};
            9'h023: m = {1'b1, 3'd1, 3'd3};
            9'h024: m = {1'b1, 3'd1, 3'd4};
            9'h02B: m = {1'b1, 3'd1, 3'd5};
            9'h034: m = {1'b1, 3'd1, 3'd6};
            9'h033: m = {1'b1, 3'd1, 3'd7};
            9'h043: m = {1'b1, 3'd2, 3'd0};
            9'h03B: m = {1'b1, 3'd2, 3'd1};
            9'h042: m = {1'b1, 3'd2, 3'd2};
            9'h04B: m = {1'b1, 3'd2, 3'd3};
            9'h03A: m = {1'b1, 3'd2, 3'd4};
            9'h031: m = {1'b1, 3'd2, 3'd5};
            9'h044: m = {1'b1, 3'd2, 3'd6};
            9'h04D: m = {1'b1, 3'd2, 3'd7};
            9'h015: m = {1'b1, 3'd3, 3'd0};
            9'h02D: m = {1'b1, 3'd3, 3'd1};
            9'h01B: m = {1'b1, 3'd3, 3'd2};
            9'h02C: m = {1'b1, 3'd3, 3'd3};
            9'h03C: m = {1'b1, 3'd3, 3'd4};
            9'h02A: m = {1'b1, 3'd3, 3'd5};
            9'h01D: m = {1'b1, 3'd3, 3'd6};
            9'h022: m = {1'b1, 3'd3, 3'd7};
            9'h035: m = {1'b1, 3'd4, 3'd0};
            9'h01A: m = {1'b1, 3'd4, 3'd1};
            9'h03E: m = {1'b1, 3'd4, 3'd2};
            9'h046: m = {1'b1, 3'd4, 3'd3};
            9'h045: m = {1'b1, 3'd4, 3'd4};
            9'h04E: m = {1'b1, 3'd4, 3'd5};
            9'h055: m = {1'b1, 3'd4, 3'd6};
            9'h066: m = {1'b1, 3'd4, 3'd7};
            9'h00D: m = {1'b1, 3'd5, 3'd0};
            9'h076: m = {1'b1, 3'd5, 3'd1};
            9'h014: m = {1'b1, 3'd5, 3'd2};
            9'h054: m = {1'b1, 3'd5, 3'd3};
            9'h05B: m = {1'b1, 3'd5, 3'd4};
            9'h04C: m = {1'b1, 3'd5, 3'd5};
            9'h052: m = {1'b1, 3'd5, 3'd6};
            9'h041: m = {1'b1, 3'd5, 3'd7};
            9'h16B: m = {1'b1, 3'd6, 3'd0};
            9'h175: m = {1'b1, 3'd6, 3'd1};
            9'h172: m = {1'b1, 3'd6, 3'd2};
            9'h174: m = {1'b1, 3'd6, 3'd3};
            9'h049: m = {1'b1, 3'd6, 3'd4};
            9'h04A: m = {1'b1, 3'd6, 3'd5};
            9'h05D: m = {1'b1, 3'd6, 3'd6};
            9'h011: m = {1'b1, 3'd6, 3'd7};
            9'h012: m = {1'b1, 3'd7, 3'd0};
            9'h059: m = {1'b1, 3'd7, 3'd0};
            9'h058: m = {1'b1, 3'd7, 3'd1};
            9'h005: m = {1'b1, 3'd7, 3'd2};
            9'h006: m = {1'b1, 3'd7, 3'd3};
            9'h029: m = {1'b1, 3'd7, 3'd4};
            9'h00E: m = {1'b1, 3'd7, 3'd5};
            9'h004: m = {1'b1, 3'd7, 3'd6};
            9'h00C: m = {1'b1, 3'd7, 3'd7};
            default: m = 7'd0;
        endcase
        return m;
    endfunction

    assign key_map = map_key({ext, rx_byte});

    // Synchronise both lines and debounce the PS/2 clock
    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            clk_sync   <= 2'b11;
            data_sync  <= 2'b11;
            filt_clk   <= 1'b1;
            filt_clk_d <= 1'b1;
            filt_cnt   <= '0;
        end else begin
            clk_sync   <= {clk_sync[0], ps2_clk};
            data_sync  <= {data_sync[0], ps2_data};
            filt_clk_d <= filt_clk;
            if (clk_sync[1] == filt_clk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt_clk <= clk_sync[1];
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    // Frame receiver: start, 8 data bits LSB first, odd parity, stop; aborts on clock silence
    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            rx_state   <= IDLE;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            parity_ok  <= 1'b0;
            tmo_cnt    <= '0;
            byte_valid <= 1'b0;
            rx_byte    <= '0;
            rx_err     <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            rx_err     <= 1'b0;
            if (rx_state != IDLE && !strobe) begin
                if (tmo_cnt == TW'(TIMEOUT - 1)) begin
                    rx_state <= IDLE;
                    rx_err   <= 1'b1;
                    tmo_cnt  <= '0;
                end else begin
                    tmo_cnt <= tmo_cnt + TW'(1);
                end
            end else begin
                tmo_cnt <= '0;
            end
            if (strobe) begin
                case (rx_state)
                    IDLE: begin
                        if (!data_s) begin
                            rx_state <= SHIFT;
                            bit_cnt  <= '0;
                        end
                    end
                    SHIFT: begin
                        shift_reg <= {data_s, shift_reg[7:1]};
                        bit_cnt   <= bit_cnt + 3'd1;
                        if (bit_cnt == 3'd7) rx_state <= PARITY;
                    end
                    PARITY: begin
                        parity_ok <= ^{shift_reg, data_s};
                        rx_state  <= STOP;
                    end
                    STOP: begin
                        if (data_s && parity_ok) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= shift_reg;
                        end else begin
                            rx_err <= 1'b1;
                        end
                        rx_state <= IDLE;
                    end
                    default: rx_state <= IDLE;
                endcase
            end
        end
    end

    // Scancode decoder: prefix flags, Pause skip, matrix update
    always_ff @(posedge sys_clock) begin
        if (RESET) begin
            KM   <= '1;
            ext  <= 1'b0;
            rel  <= 1'b0;
            skip <= '0;
`ifdef LM80C_KBD_HOTKEY_EN
            reset_req <= 1'b0;
`endif
        end else if (byte_valid) begin
            if (skip != 3'd0) begin
                skip <= skip - 3'd1;
            end else begin
                case (rx_byte)
                    8'hE1: skip <= 3'd7;
                    8'hE0: ext  <= 1'b1;
                    8'hF0: rel  <= 1'b1;
                    8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                    default: begin
                        if (key_map[6]) KM[key_map[5:3]][key_map[2:0]] <= rel;
`ifdef LM80C_KBD_HOTKEY_EN
                        if ({ext, rx_byte} == 9'h007) reset_req <= ~rel;
`endif
                        ext <= 1'b0;
                        rel <= 1'b0;
                    end
                endcase
            end
        end
    end

`ifndef LM80C_KBD_HOTKEY_EN
    assign reset_req = 1'b0;
`endif

endmodule

// File: tb/tb_lm80c_ps2_keyboard.sv
// Scoreboard bench for lm80c_ps2_keyboard: directed PS/2 frames with hand-computed matrix results.
module tb_lm80c_ps2_keyboard;

    localparam int unsigned HALF = 20;
    localparam int unsigned TMO  = 2000;

    logic            sys_clock = 1'b0;
    logic            RESET     = 1'b1;
    logic            ps2_clk   = 1'b1;
    logic            ps2_data  = 1'b1;
    logic [7:0][7:0] KM;
    logic            rx_err;
    logic            reset_req;

    typedef struct packed {
        logic        is_err;
        logic [63:0] km;
    } ev_t;

    ev_t         exp_q[$];
    logic [63:0] exp_km;
    logic [63:0] prev_km;
    logic        mon_en = 1'b0;
    int          checks = 0;
    int          errors = 0;

    lm80c_ps2_keyboard #(.FILTER_LEN(8), .TIMEOUT(TMO)) dut (
        .sys_clock(sys_clock),
        .RESET    (RESET),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data),
        .KM       (KM),
        .rx_err   (rx_err),
        .reset_req(reset_req)
    );

    always #5 sys_clock = ~sys_clock;

    task automatic tick(input int n);
        repeat (n) @(posedge sys_clock);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_data = bits[i];
            tick(HALF);
            ps2_clk = 1'b0;
            tick(HALF);
            ps2_clk = 1'b1;
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] b, input logic bad);
        return {1'b1, (~^b) ^ bad, b, 1'b0};
    endfunction

    task automatic send_byte(input logic [7:0] b);
        send_bits(frame(b, 1'b0), 11);
        ps2_data = 1'b1;
        tick(60);
    endtask

    task automatic expect_key(input int row, input int col, input logic v);
        exp_km[row*8 + col] = v;
        exp_q.push_back({1'b0, exp_km});
    endtask

    task automatic expect_err();
        exp_q.push_back({1'b1, exp_km});
    endtask

    // Monitor: every matrix change and every rx_err cycle consumes one expected event
    always @(negedge sys_clock) begin
        if (mon_en) begin
            if (KM !== prev_km) begin
                checks++;
                if (exp_q.size() == 0 || exp_q[0].is_err) begin
                    errors++;
                    $display("FAIL km_change: got %h expected no change", KM);
                end else begin
                    ev_t ev;
                    ev = exp_q.pop_front();
                    if (KM !== ev.km) begin
                        errors++;
                        $display("FAIL km_value: got %h expected %h", KM, ev.km);
                    end
                end
                prev_km = KM;
            end
            if (rx_err) begin
                checks++;
                if (exp_q.size() == 0 || !exp_q[0].is_err) begin
                    errors++;
                    $display("FAIL rx_err: got pulse expected none");
                end else begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        logic exp_rr;
        RESET = 1'b1;
        tick(5);
        @(negedge sys_clock);
        check("reset_km", KM, {64{1'b1}});
        check("reset_rx_err", 64'(rx_err), 64'd0);
        check("reset_req_init", 64'(reset_req), 64'd0);
        exp_km  = {64{1'b1}};
        prev_km = KM;
        mon_en  = 1'b1;
        RESET   = 1'b0;
        tick(20);

        expect_key(1, 0, 1'b0); send_byte(8'h1C);
        expect_key(1, 0, 1'b1); send_byte(8'hF0); send_byte(8'h1C);
        expect_key(6, 1, 1'b0); send_byte(8'hE0); send_byte(8'h75);
        expect_key(6, 1, 1'b1); send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);

        // Parity error drops the byte, the following good one lands
        expect_err();
        send_bits(frame(8'h29, 1'b1), 11);
        ps2_data = 1'b1;
        tick(60);
        expect_key(7, 4, 1'b0); send_byte(8'h29);

        // Partial frame then clock silence
        expect_err();
        send_bits(frame(8'h5A, 1'b0), 5);
        ps2_data = 1'b1;
        tick(TMO + 10);
        expect_key(0, 7, 1'b0); send_byte(8'h5A);

        // Pause sequence is swallowed whole
        send_byte(8'hE1); send_byte(8'h14); send_byte(8'h77); send_byte(8'hE1);
        send_byte(8'hF0); send_byte(8'h14); send_byte(8'hF0); send_byte(8'h77);
        expect_key(1, 0, 1'b0); send_byte(8'h1C);

        // Typematic repeat, shared shift key, ignored byte keeping the break flag
        send_byte(8'h1C);
        expect_key(7, 0, 1'b0); send_byte(8'h12);
        send_byte(8'h59);
        expect_key(7, 0, 1'b1); send_byte(8'hF0); send_byte(8'h59);
        send_byte(8'hF0); send_byte(8'h12);
        expect_key(7, 4, 1'b1); send_byte(8'hF0); send_byte(8'hAA); send_byte(8'h29);

        // F12 hotkey
`ifdef LM80C_KBD_HOTKEY_EN
        exp_rr = 1'b1;
`else
        exp_rr = 1'b0;
`endif
        send_byte(8'h07);
        @(negedge sys_clock);
        check("hotkey_make", 64'(reset_req), 64'(exp_rr));
        send_byte(8'hF0); send_byte(8'h07);
        @(negedge sys_clock);
        check("hotkey_break", 64'(reset_req), 64'd0);

        // Reset in the middle of a frame with keys held
        send_bits(frame(8'h1C, 1'b0), 4);
        ps2_data = 1'b1;
        exp_km   = {64{1'b1}};
        exp_q.push_back({1'b0, exp_km});
        @(negedge sys_clock);
        RESET = 1'b1;
        tick(3);
        @(negedge sys_clock);
        RESET = 1'b0;
        check("midframe_reset_km", KM, {64{1'b1}});
        tick(20);
        expect_key(1, 0, 1'b0); send_byte(8'h1C);

        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) tick(1);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_events: got %0d outstanding expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
